// File: rtl/midi_parser.sv
`default_nettype none
// ============================================================================
// Module   : midi_parser
// Purpose  : Turns a UART byte stream into complete MIDI channel messages.
//            Define MIDI_RUNNING_STATUS_EN to keep the status byte after each message.
// Revision : 1.0 - initial release
// ============================================================================
module midi_parser #(
   parameter int unsigned CHANNEL = 16
) (
   input  logic       clk,
   input  logic       resetq,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       msg_valid,
   output logic [7:0] command,
   output logic [7:0] value1,
   output logic [7:0] value2,
   output logic       sync_err
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT_D1 = 2'd1,
      S_WAIT_D2 = 2'd2
   } state_t;

   localparam logic       c_OMNI = (CHANNEL >= 16);
   localparam logic [3:0] c_CHAN = 4'(CHANNEL % 16);

   state_t     r_state;
   logic [7:0] r_status;
   logic [7:0] r_d1;
   logic       r_quiet;

   logic       w_is_data;
   logic       w_is_chan;
   logic       w_is_sys;
   logic       w_two_byte;
   logic       w_chan_ok;
   logic       w_final;
   logic [7:0] w_v1;
   logic [7:0] w_v2;

   assign w_is_data  = ~rx_byte[7];
   assign w_is_chan  = rx_byte[7] & (rx_byte[7:4] != 4'hF);
   assign w_is_sys   = (rx_byte[7:3] == 5'b11110);
   assign w_two_byte = (r_status[7:4] == 4'hC) | (r_status[7:4] == 4'hD);
   assign w_chan_ok  = c_OMNI | (r_status[3:0] == c_CHAN);

   // Final data byte of the current message: either d1 of a 2-byte or d2 of a 3-byte.
   assign w_final = rx_valid & w_is_data &
                    (((r_state == S_WAIT_D1) & w_two_byte) | (r_state == S_WAIT_D2));
   assign w_v1    = (r_state == S_WAIT_D2) ? r_d1 : rx_byte;
   assign w_v2    = (r_state == S_WAIT_D2) ? rx_byte : 8'h00;

   always_ff @(posedge clk) begin
      if (resetq) begin
         r_state   <= S_IDLE;
         r_status  <= 8'h00;
         r_d1      <= 8'h00;
         r_quiet   <= 1'b0;
         msg_valid <= 1'b0;
         sync_err  <= 1'b0;
         command   <= 8'h00;
         value1    <= 8'h00;
         value2    <= 8'h00;
      end else begin
         msg_valid <= 1'b0;
         sync_err  <= 1'b0;
         if (rx_valid) begin
            if (w_is_chan) begin
               r_status <= rx_byte;
               r_quiet  <= 1'b0;
               r_state  <= S_WAIT_D1;
            end else if (w_is_sys) begin
               // SysEx and friends: swallow following data silently
               r_status <= 8'h00;
               r_quiet  <= 1'b1;
               r_state  <= S_IDLE;
            end else if (w_is_data) begin
               if (w_final) begin
                  if (w_chan_ok) begin
                     command   <= r_status;
                     value1    <= w_v1;
                     value2    <= w_v2;
                     msg_valid <= 1'b1;
                  end
`ifdef MIDI_RUNNING_STATUS_EN
                  r_state  <= S_WAIT_D1;
`else
                  r_state  <= S_IDLE;
                  r_status <= 8'h00;
`endif
               end else begin
                  case (r_state)
                     S_IDLE: begin
                        if (!r_quiet) sync_err <= 1'b1;
                     end
                     S_WAIT_D1: begin
                        r_d1    <= rx_byte;
                        r_state <= S_WAIT_D2;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_midi_parser.sv
`default_nettype none
// Self-checking bench for midi_parser: directed MIDI sequences followed by random byte streams,
// checked against a message-level reference model for an omni and a channel-1 instance.
module tb_midi_parser;

`ifdef MIDI_RUNNING_STATUS_EN
   localparam bit RUN = 1'b1;
`else
   localparam bit RUN = 1'b0;
`endif
   localparam int CH[2] = '{16, 1};

   logic       clk = 1'b0;
   logic       resetq = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_byte = 8'h00;

   logic       mv  [2];
   logic       se  [2];
   logic [7:0] cmd [2];
   logic [7:0] v1  [2];
   logic [7:0] v2  [2];

   midi_parser #(.CHANNEL(16)) u_omni (
      .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .msg_valid(mv[0]), .command(cmd[0]), .value1(v1[0]), .value2(v2[0]), .sync_err(se[0])
   );

   midi_parser #(.CHANNEL(1)) u_ch1 (
      .clk(clk), .resetq(resetq), .rx_valid(rx_valid), .rx_byte(rx_byte),
      .msg_valid(mv[1]), .command(cmd[1]), .value1(v1[1]), .value2(v2[1]), .sync_err(se[1])
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: a pending status (or none), a list of collected data bytes,
   // and a "silent" flag set by system-common bytes.
   int         m_status [2];
   bit         m_silent [2];
   byte        m_data   [2][$];
   bit         e_mv [2];
   bit         e_se [2];
   logic [7:0] e_cmd [2];
   logic [7:0] e_v1  [2];
   logic [7:0] e_v2  [2];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   task automatic check_all(input string ph);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_u%0d_msg_valid", ph, k), {7'b0, mv[k]}, {7'b0, e_mv[k]});
         chk($sformatf("%s_u%0d_sync_err", ph, k), {7'b0, se[k]}, {7'b0, e_se[k]});
         chk($sformatf("%s_u%0d_command", ph, k), cmd[k], e_cmd[k]);
         chk($sformatf("%s_u%0d_value1", ph, k), v1[k], e_v1[k]);
         chk($sformatf("%s_u%0d_value2", ph, k), v2[k], e_v2[k]);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_status[k] = -1;
         m_silent[k] = 1'b0;
         m_data[k].delete();
         e_mv[k] = 1'b0; e_se[k] = 1'b0;
         e_cmd[k] = 8'h00; e_v1[k] = 8'h00; e_v2[k] = 8'h00;
      end
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int len;
      for (int k = 0; k < 2; k++) begin
         e_mv[k] = 1'b0;
         e_se[k] = 1'b0;
         if (b >= 8'hF8) begin
            // realtime: no effect at all
         end else if (b >= 8'hF0) begin
            m_status[k] = -1;
            m_silent[k] = 1'b1;
            m_data[k].delete();
         end else if (b >= 8'h80) begin
            m_status[k] = int'(b);
            m_silent[k] = 1'b0;
            m_data[k].delete();
         end else if (m_status[k] < 0) begin
            if (!m_silent[k]) e_se[k] = 1'b1;
         end else begin
            len = ((m_status[k] / 16 == 12) || (m_status[k] / 16 == 13)) ? 2 : 3;
            m_data[k].push_back(byte'(b));
            if (m_data[k].size() == len - 1) begin
               if (CH[k] == 16 || (m_status[k] % 16) == CH[k]) begin
                  e_mv[k]  = 1'b1;
                  e_cmd[k] = 8'(m_status[k]);
                  e_v1[k]  = 8'(m_data[k][0]);
                  e_v2[k]  = (len == 3) ? 8'(m_data[k][1]) : 8'h00;
               end
               m_data[k].delete();
               if (!RUN) m_status[k] = -1;
            end
         end
      end
   endfunction

   task automatic send(input logic [7:0] b, input string tag);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      model_byte(b);
      check_all(tag);
   endtask

   task automatic gap(input string tag);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         e_mv[k] = 1'b0;
         e_se[k] = 1'b0;
      end
      check_all(tag);
   endtask

   task automatic do_reset(input logic [7:0] junk);
      @(negedge clk);
      resetq   = 1'b1;
      rx_valid = 1'b1;
      rx_byte  = junk;
      @(posedge clk);
      #1;
      resetq   = 1'b0;
      rx_valid = 1'b0;
      model_reset();
      check_all("reset");
   endtask

   task automatic send_seq(input logic [7:0] seq[$], input string tag);
      foreach (seq[i]) begin
         send(seq[i], tag);
         gap(tag);
      end
   endtask

   function automatic logic [7:0] rand_byte();
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 50) return 8'($urandom_range(0, 127));
      if (sel < 80) return {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3))};
      if (sel < 90) return 8'($urandom_range(248, 255));
      return 8'($urandom_range(240, 247));
   endfunction

   initial begin
      model_reset();
      do_reset(8'h90);

      // 1: basic 3-byte note-on with 1-clk latency
      send_seq('{8'h90, 8'h3C, 8'h64}, "t1");
      // 2: 2-byte program change
      send_seq('{8'hC2, 8'h05}, "t2");
      chk("t2_value2_zero", v2[0], 8'h00);
      // 3: realtime byte in the middle of a message
      send_seq('{8'h90, 8'h3C, 8'hF8, 8'h64}, "t3");
      chk("t3_command", cmd[0], 8'h90);
      // 4: running status (or sync_err without it)
      send_seq('{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h00}, "t4");
      // 5: channel filter on the CHANNEL=1 instance
      send_seq('{8'h91, 8'h40, 8'h7F}, "t5a");
      send_seq('{8'h92, 8'h40, 8'h7F}, "t5b");
      chk("t5_ch1_command_held", cmd[1], 8'h91);
      // SysEx payload is dropped without sync_err
      send_seq('{8'hF0, 8'h12, 8'h34, 8'hF7, 8'h55}, "sysex");
      // 6: reset mid-message discards the partial message
      send_seq('{8'h90, 8'h3C}, "t6");
      do_reset(8'h64);
      send(8'h64, "t6_after");
      chk("t6_sync_err", {7'b0, se[0]}, 8'h01);
      gap("t6_after");

      // Random streams, with occasional back-to-back strobes and resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset(rand_byte());
         send(rand_byte(), "rand");
         if ($urandom_range(0, 3) != 0) gap("rand_gap");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $display("%0d/%0d checks passed", n_pass, n_total + 1);
      $fatal(1);
   end

endmodule
`default_nettype wire
